// File: rtl/ob_pkg.sv
// Shared types for the order-book side tables: order record, command
// opcodes, response status and the per-entry shift-select code.
package ob_pkg;

    localparam int OB_UID_W   = 16;
    localparam int OB_PRICE_W = 32;
    localparam int OB_QTY_W   = 16;

    typedef struct packed {
        logic [OB_UID_W-1:0]   uid;
        logic [OB_PRICE_W-1:0] price;
        logic [OB_QTY_W-1:0]   qty;
    } order_t;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_POP    = 2'd1,
        OP_CANCEL = 2'd2
    } opcode_t;

    typedef enum logic [1:0] {
        ST_OK            = 2'd0,
        ST_ERR_EMPTY     = 2'd1,
        ST_ERR_NOT_FOUND = 2'd2,
        ST_REJECTED      = 2'd3
    } status_t;

    // Where each table slot takes its next value from.
    typedef enum logic [1:0] {
        SEL_KEEP = 2'd0,
        SEL_PREV = 2'd1,   // take entry i-1 (insert shifts up)
        SEL_NEXT = 2'd2,   // take entry i+1 (remove shifts down)
        SEL_NEW  = 2'd3    // take the incoming order
    } sel_t;

    // True when price a is strictly better than price b for this side.
    function automatic logic price_better(input logic                  is_ask,
                                          input logic [OB_PRICE_W-1:0] a,
                                          input logic [OB_PRICE_W-1:0] b);
        return is_ask ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/ob_reject_fifo.sv
// Small FIFO collecting evicted or unplaceable orders. The head is held in
// a register so the consumer sees a clean output; a push into an empty
// queue is forwarded straight into the head register.
module ob_reject_fifo #(
    parameter int W = 64,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid_r,
    output logic [W-1:0] head_r,
    output logic         full_r
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    logic [W-1:0]     mem [N];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;
    logic [W-1:0]     head_nxt;

    // Qualify push/pop and work out the next count and head value.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        count_nxt = count;
        head_nxt  = '0;
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != CNT_W'(N)) || do_pop);
        rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CNT_W'(1);
        end
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = push_data;   // the entry being written becomes the head
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array written on push.
    // NOTE: the data array has no reset; only pointers and count need one.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and registered head/flags.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state always uses non-blocking assignment.
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            head_r  <= '0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            wr_ptr  <= do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
            count   <= count_nxt;
            valid_r <= (count_nxt != '0);
            full_r  <= (count_nxt == CNT_W'(N));
            head_r  <= head_nxt;
        end
    end

endmodule

// File: rtl/ob_table_sorted.sv
// One side of the order book: N resting orders kept sorted best-first
// (price, then arrival). Insert/pop/cancel are built from a per-slot select
// mux; orders pushed out of a full table go to the reject FIFO.
module ob_table_sorted
    import ob_pkg::*;
#(
    parameter int   N        = 16,
    parameter logic is_ask   = 1'b1,
    parameter int   REJECT_N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  opcode_t                cmd_opcode,
    input  order_t                 cmd_order,
    output logic                   rsp_vld_r,
    output status_t                rsp_status_r,
    output order_t                 rsp_order_r,
    output logic                   best_vld_r,
    output order_t                 best_order_r,
    output logic [$clog2(N+1)-1:0] occupancy_r,
    input  logic                   reject_pop,
    output logic                   reject_valid_r,
    output order_t                 reject_order_r
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = $clog2(N);

    order_t           tbl      [N];
    order_t           tbl_nxt  [N];
    order_t           prev_src [N];
    order_t           next_src [N];
    sel_t             sel      [N];
    logic [N-1:0]     ahead_vec;
    logic [N-1:0]     match_vec;
    int               ins_pos;
    logic             cancel_hit;
    logic [IDX_W-1:0] cancel_idx;
    logic             tbl_full;
    logic             do_ins;
    logic             do_rem;
    int               op_pos;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rej_push;
    order_t           rej_data;
    logic             rej_full;
    logic             rsp_vld_n;
    status_t          rsp_status_n;
    order_t           rsp_order_n;

    assign tbl_full = (occupancy_r == CNT_W'(N));
    assign cmd_rdy  = ~rej_full;

    // Per-entry compare vector: which valid entries stay ahead of the new
    // order (better or equal price) and which carry the cancel uid.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ahead_vec[i] = (i < int'(occupancy_r)) &&
                           !price_better(is_ask, cmd_order.price, tbl[i].price);
            match_vec[i] = (i < int'(occupancy_r)) && (tbl[i].uid == cmd_order.uid);
        end
    end

    // Insert position is the count of entries ahead; cancel picks the
    // lowest-index match.
    always_comb begin
        ins_pos    = 0;
        cancel_hit = 1'b0;
        cancel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ahead_vec[i]) ins_pos = ins_pos + 1;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                cancel_hit = 1'b1;
                cancel_idx = IDX_W'(i);
            end
        end
    end

    // Command decode: choose insert/remove position, reject push and response.
    always_comb begin
        do_ins       = 1'b0;
        do_rem       = 1'b0;
        op_pos       = 0;
        cnt_nxt      = occupancy_r;
        rej_push     = 1'b0;
        rej_data     = '0;
        rsp_vld_n    = 1'b0;
        rsp_status_n = ST_OK;
        rsp_order_n  = '0;
        for (int i = 0; i < N; i++) sel[i] = SEL_KEEP;

        if (cmd_vld && cmd_rdy) begin
            rsp_vld_n = 1'b1;
            case (cmd_opcode)
                OP_INSERT: begin
                    if (!tbl_full) begin
                        do_ins  = 1'b1;
                        op_pos  = ins_pos;
                        cnt_nxt = occupancy_r + CNT_W'(1);
                    end else if (price_better(is_ask, cmd_order.price, tbl[N-1].price)) begin
                        // Worst entry makes room; it falls off the top during the shift.
                        do_ins   = 1'b1;
                        op_pos   = ins_pos;
                        rej_push = 1'b1;
                        rej_data = tbl[N-1];
                    end else begin
                        rej_push     = 1'b1;
                        rej_data     = cmd_order;
                        rsp_status_n = ST_REJECTED;
                    end
                end
                OP_POP: begin
                    if (occupancy_r == '0) begin
                        rsp_status_n = ST_ERR_EMPTY;
                    end else begin
                        do_rem      = 1'b1;
                        op_pos      = 0;
                        rsp_order_n = tbl[0];
                        cnt_nxt     = occupancy_r - CNT_W'(1);
                    end
                end
                OP_CANCEL: begin
                    if (!cancel_hit) begin
                        rsp_status_n = ST_ERR_NOT_FOUND;
                    end else begin
                        do_rem      = 1'b1;
                        op_pos      = int'(cancel_idx);
                        rsp_order_n = tbl[cancel_idx];
                        cnt_nxt     = occupancy_r - CNT_W'(1);
                    end
                end
                default: rsp_vld_n = 1'b0;
            endcase
        end

        for (int i = 0; i < N; i++) begin
            if (do_ins) begin
                if (i == op_pos)     sel[i] = SEL_NEW;
                else if (i > op_pos) sel[i] = SEL_PREV;
            end else if (do_rem && (i >= op_pos)) begin
                sel[i] = SEL_NEXT;
            end
        end
    end

    // Per-slot select mux; zeros shift in at the ends so free slots stay clear.
    always_comb begin
        prev_src[0]   = '0;
        next_src[N-1] = '0;
        for (int i = 1; i < N; i++)     prev_src[i] = tbl[i-1];
        for (int i = 0; i < N - 1; i++) next_src[i] = tbl[i+1];
        for (int i = 0; i < N; i++) begin
            case (sel[i])
                SEL_PREV: tbl_nxt[i] = prev_src[i];
                SEL_NEXT: tbl_nxt[i] = next_src[i];
                SEL_NEW:  tbl_nxt[i] = cmd_order;
                default:  tbl_nxt[i] = tbl[i];
            endcase
        end
    end

    // Table, occupancy, best-order view and response registers. The table is
    // cleared on reset so free slots always read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) tbl[i] <= '0;
            occupancy_r  <= '0;
            best_vld_r   <= 1'b0;
            best_order_r <= '0;
            rsp_vld_r    <= 1'b0;
            rsp_status_r <= ST_OK;
            rsp_order_r  <= '0;
        end else begin
            for (int i = 0; i < N; i++) tbl[i] <= tbl_nxt[i];
            occupancy_r  <= cnt_nxt;
            best_vld_r   <= (cnt_nxt != '0);
            best_order_r <= tbl_nxt[0];
            rsp_vld_r    <= rsp_vld_n;
            rsp_status_r <= rsp_status_n;
            rsp_order_r  <= rsp_order_n;
        end
    end

    ob_reject_fifo #(
        .W ($bits(order_t)),
        .N (REJECT_N)
    ) u_reject_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rej_push),
        .push_data (rej_data),
        .pop       (reject_pop),
        .valid_r   (reject_valid_r),
        .head_r    (reject_order_r),
        .full_r    (rej_full)
    );

endmodule

// File: tb/tb_ob_table_sorted.sv
// Bench for ob_table_sorted: an ask-side and a bid-side instance, responses
// checked against a scoreboard of expected {status, order} pairs.
module tb_ob_table_sorted;
    import ob_pkg::*;

    typedef struct packed {
        status_t st;
        order_t  ord;
    } exp_t;

    logic    clk;
    logic    rst;

    logic    cmd_vld_a, cmd_rdy_a, rsp_vld_a, best_vld_a, rej_pop_a, rej_vld_a;
    opcode_t cmd_op_a;
    order_t  cmd_order_a, rsp_order_a, best_order_a, rej_order_a;
    status_t rsp_status_a;
    logic [4:0] occ_a;

    logic    cmd_vld_b, cmd_rdy_b, rsp_vld_b, best_vld_b, rej_pop_b, rej_vld_b;
    opcode_t cmd_op_b;
    order_t  cmd_order_b, rsp_order_b, best_order_b, rej_order_b;
    status_t rsp_status_b;
    logic [4:0] occ_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ob_table_sorted #(.N(16), .is_ask(1'b1), .REJECT_N(4)) dut_ask (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld_a), .cmd_rdy(cmd_rdy_a), .cmd_opcode(cmd_op_a), .cmd_order(cmd_order_a),
        .rsp_vld_r(rsp_vld_a), .rsp_status_r(rsp_status_a), .rsp_order_r(rsp_order_a),
        .best_vld_r(best_vld_a), .best_order_r(best_order_a), .occupancy_r(occ_a),
        .reject_pop(rej_pop_a), .reject_valid_r(rej_vld_a), .reject_order_r(rej_order_a)
    );

    ob_table_sorted #(.N(16), .is_ask(1'b0), .REJECT_N(4)) dut_bid (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld_b), .cmd_rdy(cmd_rdy_b), .cmd_opcode(cmd_op_b), .cmd_order(cmd_order_b),
        .rsp_vld_r(rsp_vld_b), .rsp_status_r(rsp_status_b), .rsp_order_r(rsp_order_b),
        .best_vld_r(best_vld_b), .best_order_r(best_order_b), .occupancy_r(occ_b),
        .reject_pop(rej_pop_b), .reject_valid_r(rej_vld_b), .reject_order_r(rej_order_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic order_t mk(input int uid, input int price);
        order_t o;
        o.uid   = 16'(uid);
        o.price = 32'(price);
        o.qty   = 16'(uid + 7);
        return o;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one command for one cycle and record the response it must produce.
    task automatic send(input bit bid, input opcode_t op, input order_t o,
                        input status_t st, input order_t eo);
        exp_t e;
        e.st  = st;
        e.ord = eo;
        @(negedge clk);
        if (bid) begin
            check("bid_cmd_rdy", 64'(cmd_rdy_b), 64'd1);
            cmd_vld_b = 1'b1; cmd_op_b = op; cmd_order_b = o;
            q_b.push_back(e);
        end else begin
            check("ask_cmd_rdy", 64'(cmd_rdy_a), 64'd1);
            cmd_vld_a = 1'b1; cmd_op_a = op; cmd_order_a = o;
            q_a.push_back(e);
        end
        @(negedge clk);
        cmd_vld_a = 1'b0;
        cmd_vld_b = 1'b0;
    endtask

    // Ask-side response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_vld_a) begin
            if (q_a.size() == 0) begin
                check("ask_rsp_spurious", 64'(rsp_vld_a), 64'd0);
            end else begin
                e = q_a.pop_front();
                check("ask_rsp_status", 64'(rsp_status_a), 64'(e.st));
                check("ask_rsp_order", rsp_order_a, e.ord);
            end
        end
    end

    // Bid-side response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_vld_b) begin
            if (q_b.size() == 0) begin
                check("bid_rsp_spurious", 64'(rsp_vld_b), 64'd0);
            end else begin
                e = q_b.pop_front();
                check("bid_rsp_status", 64'(rsp_status_b), 64'(e.st));
                check("bid_rsp_order", rsp_order_b, e.ord);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        order_t exp_heads [4];
        cmd_vld_a = 1'b0; cmd_op_a = OP_INSERT; cmd_order_a = '0; rej_pop_a = 1'b0;
        cmd_vld_b = 1'b0; cmd_op_b = OP_INSERT; cmd_order_b = '0; rej_pop_b = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        idle(3);

        // Reset state
        check("rst_occ", 64'(occ_a), 64'd0);
        check("rst_best_vld", 64'(best_vld_a), 64'd0);
        check("rst_best_order", best_order_a, 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld_a), 64'd0);
        check("rst_rej_vld", 64'(rej_vld_a), 64'd0);
        check("rst_cmd_rdy", 64'(cmd_rdy_a), 64'd1);
        rst = 1'b1;
        idle(1);

        // 1: ask ordering 40,50,60
        send(0, OP_INSERT, mk(1, 50), ST_OK, '0);
        send(0, OP_INSERT, mk(2, 40), ST_OK, '0);
        send(0, OP_INSERT, mk(3, 60), ST_OK, '0);
        idle(2);
        check("t1_best", best_order_a, mk(2, 40));
        check("t1_best_vld", 64'(best_vld_a), 64'd1);
        check("t1_occ", 64'(occ_a), 64'd3);
        send(0, OP_POP, '0, ST_OK, mk(2, 40));
        send(0, OP_POP, '0, ST_OK, mk(1, 50));
        send(0, OP_POP, '0, ST_OK, mk(3, 60));

        // 2: bid ordering with time priority at equal price
        send(1, OP_INSERT, mk(1, 50), ST_OK, '0);
        send(1, OP_INSERT, mk(2, 50), ST_OK, '0);
        send(1, OP_INSERT, mk(3, 70), ST_OK, '0);
        idle(2);
        check("t2_best", best_order_b, mk(3, 70));
        check("t2_occ", 64'(occ_b), 64'd3);
        send(1, OP_POP, '0, ST_OK, mk(3, 70));
        idle(2);
        check("t2_best_after_pop", best_order_b, mk(1, 50));
        send(1, OP_POP, '0, ST_OK, mk(1, 50));
        send(1, OP_POP, '0, ST_OK, mk(2, 50));
        send(1, OP_POP, '0, ST_ERR_EMPTY, '0);

        // 5: error responses and cancel of a middle entry
        send(0, OP_POP, '0, ST_ERR_EMPTY, '0);
        send(0, OP_CANCEL, mk(9, 0), ST_ERR_NOT_FOUND, '0);
        send(0, OP_INSERT, mk(11, 10), ST_OK, '0);
        send(0, OP_INSERT, mk(12, 20), ST_OK, '0);
        send(0, OP_INSERT, mk(13, 30), ST_OK, '0);
        send(0, OP_CANCEL, mk(12, 0), ST_OK, mk(12, 20));
        idle(2);
        check("t5_occ", 64'(occ_a), 64'd2);
        send(0, OP_POP, '0, ST_OK, mk(11, 10));
        send(0, OP_POP, '0, ST_OK, mk(13, 30));

        // 3: full table eviction and rejection
        for (int p = 100; p <= 115; p++) send(0, OP_INSERT, mk(p, p), ST_OK, '0);
        idle(2);
        check("t3_occ_full", 64'(occ_a), 64'd16);
        check("t3_best", best_order_a, mk(100, 100));
        check("t3_rej_empty", 64'(rej_vld_a), 64'd0);
        send(0, OP_INSERT, mk(99, 99), ST_OK, '0);
        check("t3_evict_vld", 64'(rej_vld_a), 64'd1);
        check("t3_evict_order", rej_order_a, mk(115, 115));
        idle(1);
        check("t3_best_new", best_order_a, mk(99, 99));
        check("t3_occ_still_full", 64'(occ_a), 64'd16);
        send(0, OP_INSERT, mk(200, 200), ST_REJECTED, '0);

        // 4: fill reject queue, back-pressure, drain in order
        send(0, OP_INSERT, mk(201, 201), ST_REJECTED, '0);
        send(0, OP_INSERT, mk(202, 202), ST_REJECTED, '0);
        idle(1);
        check("t4_cmd_rdy_low", 64'(cmd_rdy_a), 64'd0);
        exp_heads[0] = mk(115, 115);
        exp_heads[1] = mk(200, 200);
        exp_heads[2] = mk(201, 201);
        exp_heads[3] = mk(202, 202);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_head%0d", k), rej_order_a, exp_heads[k]);
            rej_pop_a = 1'b1;
            @(negedge clk);
            rej_pop_a = 1'b0;
            if (k == 0) check("t4_cmd_rdy_high", 64'(cmd_rdy_a), 64'd1);
        end
        check("t4_drained_vld", 64'(rej_vld_a), 64'd0);
        check("t4_drained_order", rej_order_a, 64'd0);

        // Push into an empty queue while pop is held
        rej_pop_a = 1'b1;
        idle(1);
        send(0, OP_INSERT, mk(300, 300), ST_REJECTED, '0);
        rej_pop_a = 1'b0;
        check("t4_bypass_vld", 64'(rej_vld_a), 64'd1);
        check("t4_bypass_order", rej_order_a, mk(300, 300));
        rej_pop_a = 1'b1;
        @(negedge clk);
        rej_pop_a = 1'b0;
        check("t4_bypass_popped", 64'(rej_vld_a), 64'd0);

        // 6: reset with 5 entries and an insert in flight
        for (int u = 99; u <= 109; u++) send(0, OP_POP, '0, ST_OK, mk(u, u));
        idle(2);
        check("t6_occ_before", 64'(occ_a), 64'd5);
        @(negedge clk);
        cmd_vld_a = 1'b1; cmd_op_a = OP_INSERT; cmd_order_a = mk(55, 55);
        #2 rst = 1'b0;
        @(negedge clk);
        cmd_vld_a = 1'b0;
        check("t6_occ", 64'(occ_a), 64'd0);
        check("t6_best_vld", 64'(best_vld_a), 64'd0);
        check("t6_best_order", best_order_a, 64'd0);
        check("t6_rsp_vld", 64'(rsp_vld_a), 64'd0);
        check("t6_rsp_status", 64'(rsp_status_a), 64'(ST_OK));
        check("t6_rsp_order", rsp_order_a, 64'd0);
        check("t6_rej_vld", 64'(rej_vld_a), 64'd0);
        check("t6_rej_order", rej_order_a, 64'd0);
        idle(2);
        rst = 1'b1;
        idle(1);
        check("t6_no_rsp_after", 64'(rsp_vld_a), 64'd0);
        send(0, OP_INSERT, mk(7, 77), ST_OK, '0);
        idle(1);
        check("t6_first_insert", best_order_a, mk(7, 77));
        check("t6_first_occ", 64'(occ_a), 64'd1);

        idle(3);
        check("ask_rsp_outstanding", 64'(q_a.size()), 64'd0);
        check("bid_rsp_outstanding", 64'(q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
